present_share_loader: RTL

- Upstream front end of the masked PRESENT encryption core.
- Accepts an unmasked 128-bit key and 64-bit plaintext over a narrow valid/ready word bus. Converts each word into a d-share Boolean sharing using fresh randomness.
- Holds the full sharings stable on the core's plaintext/key inputs, issues a one-cycle start pulse, then waits for the core's valid_out before accepting the next job.

---
 rtl/present_share_loader_if.sv | 13 +
 rtl/present_share_loader.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/present_share_loader_if.sv
// Word-bus handshake between a key/plaintext source and present_share_loader.
interface present_share_loader_if #(
    parameter int unsigned D    = 2,
    parameter int unsigned BUSW = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [BUSW-1:0]       in_data;
    logic [(D-1)*BUSW-1:0] rnd_in;

    modport master (output in_valid, output in_data, output rnd_in, input  in_ready);
    modport slave  (input  in_valid, input  in_data, input  rnd_in, output in_ready);
endinterface

// File: rtl/present_share_loader.sv
// Masked PRESENT front end: shares key/plaintext words into d-share registers, pulses start, waits for core_done.
// Optional macro KEY_REUSE_EN adds reuse_key to skip the key phase and keep the previous key sharing.
module present_share_loader #(
    parameter int unsigned D      = 2,
    parameter int unsigned NBITS  = 64,
    parameter int unsigned NKBITS = 128,
    parameter int unsigned BUSW   = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    present_share_loader_if.slave bus,
    output logic [D*NBITS-1:0]    plaintext_sh,
    output logic [D*NKBITS-1:0]   key_sh,
    output logic                  start,
    input  logic                  core_done,
`ifdef KEY_REUSE_EN
    input  logic                  reuse_key,
`endif
    output logic                  busy
);

    localparam int unsigned KEY_WORDS = NKBITS / BUSW;
    localparam int unsigned PT_WORDS  = NBITS / BUSW;
    localparam int unsigned MAX_WORDS = (KEY_WORDS > PT_WORDS) ? KEY_WORDS : PT_WORDS;
    localparam int unsigned CNT_W     = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
    localparam int unsigned WSH_W     = BUSW * D;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_KEY = 3'd1,
        LOAD_PT  = 3'd2,
        FIRE     = 3'd3,
        WAIT     = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [D*NKBITS-1:0]    key_sh_q, key_sh_d;
    logic [D*NBITS-1:0]     pt_sh_q, pt_sh_d;
    logic                   in_ready_q, in_ready_d;
    logic                   start_q, start_d;
    logic                   busy_q, busy_d;

    logic [BUSW-1:0]        share0_c;
    logic [WSH_W-1:0]       word_sh_c;
    logic                   accept_c;
    logic                   reuse_c;
    logic                   key_last_c;
    logic                   pt_last_c;
    int unsigned            key_base_c;
    int unsigned            pt_base_c;

    // Interleave the incoming word into d shares: bit b share s lands at b*D+s.
    always_comb begin
        share0_c  = bus.in_data;
        word_sh_c = '0;
        for (int s = 1; s < int'(D); s++) begin
            share0_c = share0_c ^ bus.rnd_in[s*int'(BUSW)-1 -: BUSW];
        end
        for (int b = 0; b < int'(BUSW); b++) begin
            word_sh_c[b*int'(D)] = share0_c[b];
            for (int s = 1; s < int'(D); s++) begin
                word_sh_c[b*int'(D)+s] = bus.rnd_in[(s-1)*int'(BUSW)+b];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_sh_d   = key_sh_q;
        pt_sh_d    = pt_sh_q;
        accept_c   = bus.in_valid & in_ready_q;
        key_last_c = (cnt_q == CNT_W'(KEY_WORDS - 1));
        pt_last_c  = (cnt_q == CNT_W'(PT_WORDS - 1));
        // Word k (MSW first) sits at share-register slot WORDS-1-k.
        key_base_c = (KEY_WORDS - 32'd1 - 32'(cnt_q)) * WSH_W;
        pt_base_c  = (PT_WORDS - 32'd1 - 32'(cnt_q)) * WSH_W;
`ifdef KEY_REUSE_EN
        reuse_c    = reuse_key & (state_q == IDLE);
`else
        reuse_c    = 1'b0;
`endif

        unique case (state_q)
            // cnt_q is always 0 in IDLE, so IDLE and LOAD_KEY share the key path.
            IDLE, LOAD_KEY: begin
                if (accept_c) begin
                    if (reuse_c) begin
                        pt_sh_d[pt_base_c +: WSH_W] = word_sh_c;
                        if (pt_last_c) begin
                            cnt_d   = '0;
                            state_d = FIRE;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = LOAD_PT;
                        end
                    end else begin
                        key_sh_d[key_base_c +: WSH_W] = word_sh_c;
                        if (key_last_c) begin
                            cnt_d   = '0;
                            state_d = LOAD_PT;
                        end else begin
                            cnt_d   = cnt_q + CNT_W'(1);
                            state_d = LOAD_KEY;
                        end
                    end
                end
            end
            LOAD_PT: begin
                if (accept_c) begin
                    pt_sh_d[pt_base_c +: WSH_W] = word_sh_c;
                    if (pt_last_c) begin
                        cnt_d   = '0;
                        state_d = FIRE;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
            end
            FIRE: state_d = WAIT;
            WAIT: begin
                if (core_done) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE) | (state_d == LOAD_KEY) | (state_d == LOAD_PT);
        start_d    = (state_d == FIRE);
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            key_sh_q   <= '0;
            pt_sh_q    <= '0;
            in_ready_q <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_sh_q   <= key_sh_d;
            pt_sh_q    <= pt_sh_d;
            in_ready_q <= in_ready_d;
            start_q    <= start_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign plaintext_sh  = pt_sh_q;
    assign key_sh        = key_sh_q;
    assign start         = start_q;
    assign busy          = busy_q;

endmodule
